// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the memory data port.
// The slave modport is the arbiter's view; master is the requester-and-memory side.
interface mem_port_arbiter_if;
   logic        i_req;
   logic [31:2] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [3:0]  d_wmask;
   logic [31:2] d_addr;
   logic [31:0] d_wd;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic [31:2] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_wmask, d_addr, d_wd, mem_rd,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_addr, mem_we, mem_wmask, mem_wd
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_wmask, d_addr, d_wd, mem_rd,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_addr, mem_we, mem_wmask, mem_wd
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory data port between instruction fetch and load/store.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);

   // A zero limit still needs a one-bit counter so the compare stays legal.
   localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic {SRC_FETCH, SRC_DATA} src_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] starve_cnt;
   logic             i_gnt;
   logic             d_gnt;
   logic             can_grant;

   logic [31:2]      lat_addr;
   logic             lat_we;
   logic [3:0]       lat_wmask;
   logic [31:0]      lat_wd;
   src_t             lat_src;

   logic             i_rvalid_q;
   logic             d_rvalid_q;
   logic [31:0]      i_rdata_q;
   logic [31:0]      d_rdata_q;

   always_comb begin
      state_next = state;
      i_gnt      = 1'b0;
      d_gnt      = 1'b0;
      can_grant  = (state == IDLE) || (state == RESP);
      if (can_grant) begin
         if (bus.i_req && bus.d_req) begin
            if (starve_cnt == LIMIT) i_gnt = 1'b1;
            else                     d_gnt = 1'b1;
         end else if (bus.i_req) begin
            i_gnt = 1'b1;
         end else if (bus.d_req) begin
            d_gnt = 1'b1;
         end
      end
      case (state)
         IDLE:    if (i_gnt || d_gnt) state_next = ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    state_next = (i_gnt || d_gnt) ? ACCESS : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state <= state_next;
         if (!bus.i_req || i_gnt)
            starve_cnt <= '0;
         else if (d_gnt && (starve_cnt != LIMIT))
            starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // Fetches never write, so their latched enable and mask are zero; write data is left alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_addr  <= '0;
         lat_we    <= 1'b0;
         lat_wmask <= '0;
         lat_wd    <= '0;
         lat_src   <= SRC_FETCH;
      end else if (i_gnt) begin
         lat_addr  <= bus.i_addr;
         lat_we    <= 1'b0;
         lat_wmask <= '0;
         lat_src   <= SRC_FETCH;
      end else if (d_gnt) begin
         lat_addr  <= bus.d_addr;
         lat_we    <= bus.d_we;
         lat_wmask <= bus.d_wmask;
         lat_wd    <= bus.d_wd;
         lat_src   <= SRC_DATA;
      end
   end

   // Read data is captured at the end of ACCESS; the rvalid pulse then covers the RESP cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         i_rvalid_q <= (state == ACCESS) && (lat_src == SRC_FETCH);
         d_rvalid_q <= (state == ACCESS) && (lat_src == SRC_DATA);
         if ((state == ACCESS) && !lat_we) begin
            if (lat_src == SRC_FETCH) i_rdata_q <= bus.mem_rd;
            else                      d_rdata_q <= bus.mem_rd;
         end
      end
   end

   assign bus.i_gnt     = i_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.i_rvalid  = i_rvalid_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_addr  = lat_addr;
   assign bus.mem_wd    = lat_wd;
   assign bus.mem_we    = (state == ACCESS) && lat_we;
   assign bus.mem_wmask = (state == ACCESS) ? lat_wmask : 4'b0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a transaction-level model
// with a shadow memory; a second instance with STARVE_LIMIT=0 covers fetch-wins-ties.
module tb_mem_port_arbiter;

   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();
   mem_port_arbiter_if bus0 ();

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));
   mem_port_arbiter #(.STARVE_LIMIT(0))     dut0 (.clk(clk), .rst(rst), .bus(bus0));

   typedef struct {
      logic [31:2] addr;
      bit          we;
      logic [3:0]  mask;
      logic [31:0] wd;
   } req_t;

   typedef struct {
      int          acc;
      bit          fetch;
      bit          we;
      logic [3:0]  mask;
      logic [31:2] addr;
      logic [31:0] wd;
      logic [31:0] data;
   } txn_t;

   req_t iq[$];
   req_t dq[$];
   txn_t txq[$];

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          free_at = 0;
   int          starve = 0;
   bit          i_granted = 1'b0;
   bit          d_granted = 1'b0;
   bit          record = 1'b0;
   string       gseq = "";
   logic [31:0] exp_i_rdata = '0;
   logic [31:0] exp_d_rdata = '0;
   logic [31:0] shadow [0:8191];

   function automatic logic [31:0] initWord(int idx);
      if (idx == 5000) return 32'h84755779;
      if (idx == 4097) return 32'h08000000;
      return 32'(idx * 32'h9E3779B1) ^ 32'h13572468;
   endfunction

   // Environment memory: unwritten words read their initial pattern.
   logic [31:0] env_mem [0:8191];
   bit          env_written [0:8191];
   logic [31:0] env_word;
   wire  [12:0] ridx = bus.mem_addr[14:2];

   assign bus.mem_rd  = env_written[ridx] ? env_mem[ridx] : initWord(int'(ridx));
   assign bus0.mem_rd = {bus0.mem_addr, 2'b00};

   always @(negedge clk) begin
      if (bus.mem_we) begin
         env_word = env_written[ridx] ? env_mem[ridx] : initWord(int'(ridx));
         for (int b = 0; b < 4; b++)
            if (bus.mem_wmask[b]) env_word[8*b +: 8] = bus.mem_wd[8*b +: 8];
         env_mem[ridx]     <= env_word;
         env_written[ridx] <= 1'b1;
      end
   end

   function automatic logic [31:0] readEnv(int idx);
      return env_written[idx] ? env_mem[idx] : initWord(idx);
   endfunction

   function automatic req_t mkReq(logic [31:2] addr, bit we, logic [3:0] mask, logic [31:0] wd);
      req_t r;
      r.addr = addr; r.we = we; r.mask = mask; r.wd = wd;
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Advance to just after the next edge and present the head of each request queue.
   task automatic applyStimulus(input bit rand_mode);
      @(posedge clk); #1;
      if (i_granted && iq.size() > 0) void'(iq.pop_front());
      if (d_granted && dq.size() > 0) void'(dq.pop_front());
      if (rand_mode) begin
         if (iq.size() < 2 && $urandom_range(0, 2) == 0)
            iq.push_back(mkReq(30'($urandom_range(0, 63)), 1'b0, 4'h0, 32'h0));
         if (dq.size() < 2 && $urandom_range(0, 1) == 0)
            dq.push_back(mkReq(30'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                               4'($urandom_range(0, 15)), $urandom));
         if (iq.size() > 0 && $urandom_range(0, 15) == 0) void'(iq.pop_front());
      end
      bus.i_req = (iq.size() > 0);
      if (iq.size() > 0) bus.i_addr = iq[0].addr;
      bus.d_req = (dq.size() > 0);
      if (dq.size() > 0) begin
         bus.d_addr  = dq[0].addr;
         bus.d_we    = dq[0].we;
         bus.d_wmask = dq[0].mask;
         bus.d_wd    = dq[0].wd;
      end
   endtask

   // Transaction-level model: one access in flight, next grant two cycles after the last.
   task automatic evalCycle();
      bit          ireq, dreq, eig, edg, exp_we, exp_iv, exp_dv;
      logic [3:0]  exp_mask;
      txn_t        t;
      int          idx;
      #2;
      ireq = bus.i_req;
      dreq = bus.d_req;
      exp_we = 1'b0; exp_mask = 4'h0; exp_iv = 1'b0; exp_dv = 1'b0;
      if (txq.size() > 0 && txq[0].acc == cyc) begin
         t = txq[0];
         idx = int'(t.addr[14:2]);
         t.data = shadow[idx];
         if (t.we) begin
            for (int b = 0; b < 4; b++)
               if (t.mask[b]) shadow[idx][8*b +: 8] = t.wd[8*b +: 8];
            checkOutput("mem_wd", bus.mem_wd, t.wd);
         end
         exp_we   = t.we;
         exp_mask = t.mask;
         checkOutput("mem_addr", {bus.mem_addr, 2'b00}, {t.addr, 2'b00});
         txq[0] = t;
      end else if (txq.size() > 0 && txq[0].acc + 1 == cyc) begin
         t = txq.pop_front();
         if (t.fetch) begin
            exp_iv = 1'b1;
            exp_i_rdata = t.data;
         end else begin
            exp_dv = 1'b1;
            if (!t.we) exp_d_rdata = t.data;
         end
      end
      checkOutput("mem_we", bus.mem_we, exp_we);
      checkOutput("mem_wmask", bus.mem_wmask, exp_mask);
      checkOutput("i_rvalid", bus.i_rvalid, exp_iv);
      checkOutput("d_rvalid", bus.d_rvalid, exp_dv);
      checkOutput("i_rdata", bus.i_rdata, exp_i_rdata);
      checkOutput("d_rdata", bus.d_rdata, exp_d_rdata);

      eig = 1'b0; edg = 1'b0;
      if (cyc >= free_at) begin
         if (ireq && dreq) begin
            if (starve == LIMIT) eig = 1'b1;
            else                 edg = 1'b1;
         end else if (ireq) eig = 1'b1;
         else if (dreq)     edg = 1'b1;
      end
      checkOutput("i_gnt", bus.i_gnt, eig);
      checkOutput("d_gnt", bus.d_gnt, edg);
      if (!ireq || eig) starve = 0;
      else if (edg && starve < LIMIT) starve++;
      if (eig || edg) begin
         free_at  = cyc + 2;
         t.acc    = cyc + 1;
         t.fetch  = eig;
         t.we     = eig ? 1'b0 : bus.d_we;
         t.mask   = eig ? 4'h0 : bus.d_wmask;
         t.addr   = eig ? bus.i_addr : bus.d_addr;
         t.wd     = bus.d_wd;
         t.data   = '0;
         txq.push_back(t);
      end
      if (record && gseq.len() < 10) begin
         if (bus.i_gnt) gseq = {gseq, "I"};
         if (bus.d_gnt) gseq = {gseq, "D"};
      end
      i_granted = bus.i_gnt;
      d_granted = bus.d_gnt;
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      while ((iq.size() > 0 || dq.size() > 0 || txq.size() > 0) && n < 100) begin
         applyStimulus(1'b0);
         evalCycle();
         n++;
      end
      checkOutput("drain_done", (iq.size() + dq.size() + txq.size() == 0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   // Asserts reset right now, checks the asynchronous clear, holds two edges and releases.
   task automatic doReset();
      rst = 1'b0;
      iq.delete(); dq.delete(); txq.delete();
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      i_granted = 1'b0; d_granted = 1'b0;
      starve = 0; free_at = 0;
      exp_i_rdata = '0; exp_d_rdata = '0;
      #1;
      checkOutput("rst_i_gnt", bus.i_gnt, 0);
      checkOutput("rst_d_gnt", bus.d_gnt, 0);
      checkOutput("rst_i_rvalid", bus.i_rvalid, 0);
      checkOutput("rst_d_rvalid", bus.d_rvalid, 0);
      checkOutput("rst_mem_we", bus.mem_we, 0);
      checkOutput("rst_mem_wmask", bus.mem_wmask, 0);
      checkOutput("rst_mem_addr", {bus.mem_addr, 2'b00}, 0);
      checkOutput("rst_mem_wd", bus.mem_wd, 0);
      checkOutput("rst_i_rdata", bus.i_rdata, 0);
      checkOutput("rst_d_rdata", bus.d_rdata, 0);
      repeat (2) begin
         @(posedge clk); #1;
         checkOutput("rst_hold_ivalid", bus.i_rvalid, 0);
         checkOutput("rst_hold_dvalid", bus.d_rvalid, 0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) shadow[i] = initWord(i);
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wmask = '0; bus.d_addr = '0; bus.d_wd = '0;
      bus0.i_req = 1'b0; bus0.i_addr = '0;
      bus0.d_req = 1'b0; bus0.d_we = 1'b0; bus0.d_wmask = '0; bus0.d_addr = '0; bus0.d_wd = '0;

      doReset();
      repeat (4) begin applyStimulus(1'b0); evalCycle(); end

      iq.push_back(mkReq(30'd5000, 1'b0, 4'h0, 32'h0));
      drain();
      checkOutput("read_5000", bus.i_rdata, 32'h84755779);

      dq.push_back(mkReq(30'd4097, 1'b1, 4'b0011, 32'hAABBCCDD));
      dq.push_back(mkReq(30'd4097, 1'b0, 4'h0, 32'h0));
      drain();
      checkOutput("partial_write_read", bus.d_rdata, 32'h0800CCDD);

      record = 1'b1;
      for (int k = 0; k < 10; k++) begin
         iq.push_back(mkReq(30'(100 + k), 1'b0, 4'h0, 32'h0));
         dq.push_back(mkReq(30'(200 + k), 1'b0, 4'h0, 32'h0));
      end
      drain();
      record = 1'b0;
      checkOutput("contention_seq", (gseq == "DDDDIDDDDI") ? 32'd1 : 32'd0, 32'd1);

      for (int k = 10; k < 13; k++) dq.push_back(mkReq(30'(k), 1'b0, 4'h0, 32'h0));
      drain();

      dq.push_back(mkReq(30'd20, 1'b1, 4'hF, 32'hDEADBEEF));
      applyStimulus(1'b0);
      evalCycle();
      @(posedge clk); #1;
      checkOutput("access_mem_we", bus.mem_we, 1);
      doReset();
      repeat (3) begin applyStimulus(1'b0); evalCycle(); end
      iq.push_back(mkReq(30'd20, 1'b0, 4'h0, 32'h0));
      drain();

      repeat (400) begin applyStimulus(1'b1); evalCycle(); end
      drain();

      for (int i = 0; i < 64; i++) checkOutput("mem_final", readEnv(i), shadow[i]);
      checkOutput("mem_final_4097", readEnv(4097), shadow[4097]);

      @(posedge clk); #1;
      bus0.i_req = 1'b1; bus0.i_addr = 30'd7;
      bus0.d_req = 1'b1; bus0.d_addr = 30'd9;
      for (int k = 0; k < 12; k++) begin
         #2;
         checkOutput("l0_i_gnt", bus0.i_gnt, (k % 2 == 0) ? 32'd1 : 32'd0);
         checkOutput("l0_d_gnt", bus0.d_gnt, 0);
         checkOutput("l0_i_rvalid", bus0.i_rvalid, (k >= 2 && k % 2 == 0) ? 32'd1 : 32'd0);
         checkOutput("l0_d_rvalid", bus0.d_rvalid, 0);
         @(posedge clk); #1;
      end
      checkOutput("l0_i_rdata", bus0.i_rdata, 32'd28);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
